ring_decode: RTL and testbench

RING_DECODE -- requirements
Module: ring_decode

---
 rtl/ring_decode.sv | 205 ++++++++++++++++++++
 tb/tb_ring_decode.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ring_decode.sv
// ---------------------------------------------------------------------------
// ring_decode
//
// Purpose:
//   Watches a ring counter and decodes it. Each sample taken while ring_vld
//   is high is checked for legality (exactly one bit set). The position of
//   the set bit is reported in binary. A small tracker confirms that the
//   ring rotates right, one position per accepted sample, with bit 0
//   wrapping to the MSB. The tracker then counts complete revolutions and
//   flags sequence errors.
//
// Ports:
//   clk        - sole clock, rising edge
//   rst        - asynchronous, active-high reset
//   ring_in    - ring-counter state to decode (CNT_SIZE bits)
//   ring_vld   - ring_in is accepted on an edge only when this is high
//   clr_err    - clears err / err_cnt (a coincident new error still wins)
//   idx        - binary position of the set bit in the last legal sample
//   onehot_ok  - last accepted sample had exactly one bit set
//   locked     - tracker is following a correct right rotation
//   rev_pulse  - one-cycle pulse for each completed revolution
//   rev_cnt    - revolution count, wraps 255 -> 0
//   err        - sticky sequence-error flag
//   err_cnt    - sequence-error count, saturates at 255
//
// All outputs are registered. A sample accepted on edge k shows up in the
// outputs right after edge k.
// ---------------------------------------------------------------------------
module ring_decode #(
    parameter int CNT_SIZE = 8,
    parameter int IDX_W    = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CNT_SIZE-1:0] ring_in,
    input  logic                ring_vld,
    input  logic                clr_err,
    output logic [IDX_W-1:0]    idx,
    output logic                onehot_ok,
    output logic                locked,
    output logic                rev_pulse,
    output logic [7:0]          rev_cnt,
    output logic                err,
    output logic [7:0]          err_cnt
);

    // Tracker states. SEARCH waits for any legal sample. CONFIRM holds one
    // candidate position and waits for its right-rotation successor.
    // LOCKED follows the rotation and treats any deviation as an error.
    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        CONFIRM = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic               sample_nonzero;
    logic               sample_multi;
    logic               sample_legal;
    logic [IDX_W-1:0]   sample_pos;
    logic [IDX_W-1:0]   expected_pos;
    logic               in_sequence;
    logic               wrap_step;
    logic               seq_error;
    logic               count_rev;

    // Sample decode. A vector is one-hot when it is non-zero and clearing
    // its lowest set bit leaves nothing behind. The position encoder ORs the
    // index of every set bit. For a legal sample this gives exactly the
    // position of the single set bit. For an illegal sample the value is
    // meaningless, and it is never used because idx only loads on legal
    // samples.
    always_comb begin
        sample_nonzero = |ring_in;
        sample_multi   = |(ring_in & (ring_in - CNT_SIZE'(1)));
        sample_legal   = sample_nonzero && !sample_multi;
        sample_pos     = '0;
        for (int i = 0; i < CNT_SIZE; i++) begin
            if (ring_in[i]) begin
                sample_pos = sample_pos | IDX_W'(i);
            end
        end
    end

    // Successor prediction. idx always holds the last legal position, and
    // that is also the position the tracker is waiting to see succeeded. A
    // right rotation moves the set bit down by one, and position 0 wraps to
    // the MSB. Stepping out of position 0 is what marks a finished
    // revolution.
    always_comb begin
        expected_pos = (idx == '0) ? IDX_W'(CNT_SIZE - 1) : (idx - IDX_W'(1));
        in_sequence  = sample_legal && (sample_pos == expected_pos);
        wrap_step    = in_sequence && (idx == '0);
    end

    // State register for the tracker. Reset always drops back to SEARCH, so
    // that no history survives a reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SEARCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic for the tracker, plus the per-edge events it raises.
    // Nothing moves while ring_vld is low. Mismatches in CONFIRM simply
    // retrain on the new position. Only LOCKED reports errors. The step that
    // enters LOCKED counts as a revolution when it wraps 0 -> MSB, the same
    // as any wrap taken while already locked.
    always_comb begin
        state_next = state;
        seq_error  = 1'b0;
        count_rev  = 1'b0;
        if (ring_vld) begin
            case (state)
                SEARCH: begin
                    if (sample_legal) begin
                        state_next = CONFIRM;
                    end
                end
                CONFIRM: begin
                    if (!sample_legal) begin
                        state_next = SEARCH;
                    end else if (in_sequence) begin
                        state_next = LOCKED;
                        count_rev  = wrap_step;
                    end
                end
                LOCKED: begin
                    if (in_sequence) begin
                        count_rev = wrap_step;
                    end else begin
                        state_next = SEARCH;
                        seq_error  = 1'b1;
                    end
                end
                default: begin
                    state_next = SEARCH;
                end
            endcase
        end
    end

    // Decode outputs. onehot_ok reflects every accepted sample. idx only
    // takes legal positions, so after a bad sample it still shows where the
    // ring last was. locked comes from the next state, so it is a registered
    // copy of "the tracker is in LOCKED" without any extra cycle of lag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx       <= '0;
            onehot_ok <= 1'b0;
            locked    <= 1'b0;
        end else begin
            locked <= (state_next == LOCKED);
            if (ring_vld) begin
                onehot_ok <= sample_legal;
                if (sample_legal) begin
                    idx <= sample_pos;
                end
            end
        end
    end

    // Revolution bookkeeping. The pulse is rebuilt every cycle, so it
    // falls back to 0 on any edge that does not complete a revolution. This
    // includes idle edges. The counter is free-running modulo 256.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rev_pulse <= 1'b0;
            rev_cnt   <= 8'd0;
        end else begin
            rev_pulse <= count_rev;
            if (count_rev) begin
                rev_cnt <= rev_cnt + 8'd1;
            end
        end
    end

    // Error bookkeeping. A new error takes priority over a clear. If both
    // land on the same edge, the clear wipes the old count and the new error
    // is then counted on top of it, so the result is exactly 1. The
    // counter saturates rather than wrapping. This keeps a burst of errors
    // from ever reading back as "few errors". clr_err works whether or not
    // a sample is being accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err     <= 1'b0;
            err_cnt <= 8'd0;
        end else if (seq_error) begin
            err <= 1'b1;
            if (clr_err) begin
                err_cnt <= 8'd1;
            end else if (err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end else if (clr_err) begin
            err     <= 1'b0;
            err_cnt <= 8'd0;
        end
    end

endmodule

// File: tb/tb_ring_decode.sv
// ---------------------------------------------------------------------------
// tb_ring_decode
//
// Purpose:
//   Directed test bench for ring_decode with CNT_SIZE=8. Every expected
//   value is worked out by hand from the intended behaviour. Inputs change
//   on the falling edge, and outputs are sampled 1 ns after the rising edge
//   that accepted the sample.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_ring_decode;

    localparam int CNT_SIZE = 8;
    localparam int IDX_W    = 3;

    logic                clk;
    logic                rst;
    logic [CNT_SIZE-1:0] ring_in;
    logic                ring_vld;
    logic                clr_err;
    logic [IDX_W-1:0]    idx;
    logic                onehot_ok;
    logic                locked;
    logic                rev_pulse;
    logic [7:0]          rev_cnt;
    logic                err;
    logic [7:0]          err_cnt;

    int checks;
    int failures;

    ring_decode #(
        .CNT_SIZE(CNT_SIZE),
        .IDX_W   (IDX_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ring_in  (ring_in),
        .ring_vld (ring_vld),
        .clr_err  (clr_err),
        .idx      (idx),
        .onehot_ok(onehot_ok),
        .locked   (locked),
        .rev_pulse(rev_pulse),
        .rev_cnt  (rev_cnt),
        .err      (err),
        .err_cnt  (err_cnt)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one sample for exactly one rising edge. Leave the outputs
    // ready to be sampled 1 ns after that edge.
    task automatic drive_sample(input logic [CNT_SIZE-1:0] value, input logic clr);
        @(negedge clk);
        ring_in  = value;
        ring_vld = 1'b1;
        clr_err  = clr;
        @(posedge clk);
        #1;
        ring_vld = 1'b0;
        clr_err  = 1'b0;
    endtask

    // One idle rising edge with ring_vld low.
    task automatic drive_idle();
        @(posedge clk);
        #1;
    endtask

    // Short reset pulse released between clock edges.
    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    // Reset asserted before any clock edge must clear everything.
    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({idx, onehot_ok, locked, rev_pulse, rev_cnt, err, err_cnt} !== 22'd0) begin
            failures++;
            $display("[TB] FAIL reset_state: got idx=%0d ok=%0b lk=%0b rp=%0b rc=%0d e=%0b ec=%0d expected all 0",
                     idx, onehot_ok, locked, rev_pulse, rev_cnt, err, err_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Lock onto a rotation and count revolutions. The 0->7 step that enters
    // LOCKED counts as the first revolution.
    task automatic test_lock_revolution();
        logic [7:0] seq [7];
        seq = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};

        drive_sample(8'h01, 1'b0);
        checks++;
        if ({idx, onehot_ok, locked} !== {3'd0, 1'b1, 1'b0}) begin
            failures++;
            $display("[TB] FAIL lock_first: got idx=%0d ok=%0b lk=%0b expected idx=0 ok=1 lk=0",
                     idx, onehot_ok, locked);
        end

        drive_sample(8'h80, 1'b0);
        checks++;
        if ({idx, locked, rev_pulse, rev_cnt} !== {3'd7, 1'b1, 1'b1, 8'd1}) begin
            failures++;
            $display("[TB] FAIL lock_enter: got idx=%0d lk=%0b rp=%0b rc=%0d expected idx=7 lk=1 rp=1 rc=1",
                     idx, locked, rev_pulse, rev_cnt);
        end

        for (int i = 0; i < 7; i++) begin
            drive_sample(seq[i], 1'b0);
            checks++;
            if ({idx, locked, rev_pulse, err} !== {3'(6 - i), 1'b1, 1'b0, 1'b0}) begin
                failures++;
                $display("[TB] FAIL lock_track step %0d: got idx=%0d lk=%0b rp=%0b e=%0b expected idx=%0d lk=1 rp=0 e=0",
                         i, idx, locked, rev_pulse, err, 6 - i);
            end
        end

        drive_sample(8'h80, 1'b0);
        checks++;
        if ({idx, rev_pulse, rev_cnt} !== {3'd7, 1'b1, 8'd2}) begin
            failures++;
            $display("[TB] FAIL second_rev: got idx=%0d rp=%0b rc=%0d expected idx=7 rp=1 rc=2",
                     idx, rev_pulse, rev_cnt);
        end

        drive_idle();
        checks++;
        if ({rev_pulse, rev_cnt, locked} !== {1'b0, 8'd2, 1'b1}) begin
            failures++;
            $display("[TB] FAIL rev_pulse_width: got rp=%0b rc=%0d lk=%0b expected rp=0 rc=2 lk=1",
                     rev_pulse, rev_cnt, locked);
        end
    endtask

    // A multi-bit sample while locked is an error. idx holds its value, and
    // the next two in-order samples relock.
    task automatic test_illegal_locked();
        drive_sample(8'h40, 1'b0);
        drive_sample(8'h03, 1'b0);
        checks++;
        if ({onehot_ok, err, err_cnt, locked, idx} !== {1'b0, 1'b1, 8'd1, 1'b0, 3'd6}) begin
            failures++;
            $display("[TB] FAIL illegal_locked: got ok=%0b e=%0b ec=%0d lk=%0b idx=%0d expected ok=0 e=1 ec=1 lk=0 idx=6",
                     onehot_ok, err, err_cnt, locked, idx);
        end

        drive_sample(8'h10, 1'b0);
        checks++;
        if ({idx, locked, err} !== {3'd4, 1'b0, 1'b1}) begin
            failures++;
            $display("[TB] FAIL relock_confirm: got idx=%0d lk=%0b e=%0b expected idx=4 lk=0 e=1",
                     idx, locked, err);
        end

        drive_sample(8'h08, 1'b0);
        checks++;
        if ({idx, locked, err_cnt, onehot_ok} !== {3'd3, 1'b1, 8'd1, 1'b1}) begin
            failures++;
            $display("[TB] FAIL relock: got idx=%0d lk=%0b ec=%0d ok=%0b expected idx=3 lk=1 ec=1 ok=1",
                     idx, locked, err_cnt, onehot_ok);
        end
    endtask

    // clr_err on its own clears the error bookkeeping. It leaves the
    // tracking state, idx and rev_cnt alone.
    task automatic test_clear_error();
        @(negedge clk);
        clr_err = 1'b1;
        @(posedge clk);
        #1;
        clr_err = 1'b0;
        checks++;
        if ({err, err_cnt, locked, idx, rev_cnt} !== {1'b0, 8'd0, 1'b1, 3'd3, 8'd2}) begin
            failures++;
            $display("[TB] FAIL clear_error: got e=%0b ec=%0d lk=%0b idx=%0d rc=%0d expected e=0 ec=0 lk=1 idx=3 rc=2",
                     err, err_cnt, locked, idx, rev_cnt);
        end
    endtask

    // After a reset, a left rotation (0->1) stays in CONFIRM and raises no
    // error. The correct successor then locks.
    task automatic test_wrong_direction();
        pulse_reset();
        drive_sample(8'h01, 1'b0);
        drive_sample(8'h02, 1'b0);
        checks++;
        if ({idx, locked, err} !== {3'd1, 1'b0, 1'b0}) begin
            failures++;
            $display("[TB] FAIL wrong_dir: got idx=%0d lk=%0b e=%0b expected idx=1 lk=0 e=0",
                     idx, locked, err);
        end

        drive_sample(8'h01, 1'b0);
        checks++;
        if ({idx, locked, err, rev_cnt} !== {3'd0, 1'b1, 1'b0, 8'd0}) begin
            failures++;
            $display("[TB] FAIL wrong_dir_lock: got idx=%0d lk=%0b e=%0b rc=%0d expected idx=0 lk=1 e=0 rc=0",
                     idx, locked, err, rev_cnt);
        end
    endtask

    // Idle cycles in the middle of a locked rotation are harmless.
    task automatic test_gaps();
        logic [7:0] seq [5];
        seq = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04};

        drive_sample(8'h80, 1'b0);
        checks++;
        if ({rev_pulse, rev_cnt} !== {1'b1, 8'd1}) begin
            failures++;
            $display("[TB] FAIL gap_rev: got rp=%0b rc=%0d expected rp=1 rc=1", rev_pulse, rev_cnt);
        end
        for (int i = 0; i < 5; i++) begin
            drive_sample(seq[i], 1'b0);
        end
        for (int i = 0; i < 5; i++) begin
            drive_idle();
            checks++;
            if ({rev_pulse, locked, idx, err} !== {1'b0, 1'b1, 3'd2, 1'b0}) begin
                failures++;
                $display("[TB] FAIL gap_idle %0d: got rp=%0b lk=%0b idx=%0d e=%0b expected rp=0 lk=1 idx=2 e=0",
                         i, rev_pulse, locked, idx, err);
            end
        end
        drive_sample(8'h02, 1'b0);
        checks++;
        if ({locked, idx, err, err_cnt} !== {1'b1, 3'd1, 1'b0, 8'd0}) begin
            failures++;
            $display("[TB] FAIL gap_resume: got lk=%0b idx=%0d e=%0b ec=%0d expected lk=1 idx=1 e=0 ec=0",
                     locked, idx, err, err_cnt);
        end
    endtask

    // 300 errors, each an all-zero sample taken while locked, with a relock
    // after each one. The count saturates at 255. A clear on the same edge
    // as a new out-of-sequence error leaves exactly one error counted.
    task automatic test_error_count();
        for (int i = 0; i < 300; i++) begin
            drive_sample(8'h00, 1'b0);
            if (i == 0 || i == 254 || i == 255) begin
                checks++;
                if ({err, err_cnt, onehot_ok, locked} !== {1'b1, ((i == 0) ? 8'd1 : 8'd255), 1'b0, 1'b0}) begin
                    failures++;
                    $display("[TB] FAIL err_count iter %0d: got e=%0b ec=%0d ok=%0b lk=%0b expected e=1 ec=%0d ok=0 lk=0",
                             i, err, err_cnt, onehot_ok, locked, (i == 0) ? 1 : 255);
                end
            end
            drive_sample(8'h20, 1'b0);
            drive_sample(8'h10, 1'b0);
        end
        checks++;
        if ({err, err_cnt, locked, idx} !== {1'b1, 8'd255, 1'b1, 3'd4}) begin
            failures++;
            $display("[TB] FAIL err_saturate: got e=%0b ec=%0d lk=%0b idx=%0d expected e=1 ec=255 lk=1 idx=4",
                     err, err_cnt, locked, idx);
        end

        drive_sample(8'h10, 1'b1);
        checks++;
        if ({err, err_cnt, locked, idx, onehot_ok} !== {1'b1, 8'd1, 1'b0, 3'd4, 1'b1}) begin
            failures++;
            $display("[TB] FAIL clr_with_error: got e=%0b ec=%0d lk=%0b idx=%0d ok=%0b expected e=1 ec=1 lk=0 idx=4 ok=1",
                     err, err_cnt, locked, idx, onehot_ok);
        end
    endtask

    // Build up rev_cnt=5 while locked. Then pulse reset between edges and
    // check that everything clears before the next edge. Tracking must
    // then start again from SEARCH.
    task automatic test_async_reset();
        logic [7:0] seq [8];
        seq = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h80};

        pulse_reset();
        drive_sample(8'h01, 1'b0);
        drive_sample(8'h80, 1'b0);
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 8; i++) begin
                drive_sample(seq[i], 1'b0);
            end
        end
        checks++;
        if ({locked, rev_cnt, idx} !== {1'b1, 8'd5, 3'd7}) begin
            failures++;
            $display("[TB] FAIL pre_reset: got lk=%0b rc=%0d idx=%0d expected lk=1 rc=5 idx=7",
                     locked, rev_cnt, idx);
        end

        #2 rst = 1'b1;
        #1;
        checks++;
        if ({idx, onehot_ok, locked, rev_pulse, rev_cnt, err, err_cnt} !== 22'd0) begin
            failures++;
            $display("[TB] FAIL async_reset: got idx=%0d ok=%0b lk=%0b rp=%0b rc=%0d e=%0b ec=%0d expected all 0",
                     idx, onehot_ok, locked, rev_pulse, rev_cnt, err, err_cnt);
        end
        #1 rst = 1'b0;

        drive_sample(8'h40, 1'b0);
        checks++;
        if ({locked, idx, onehot_ok} !== {1'b0, 3'd6, 1'b1}) begin
            failures++;
            $display("[TB] FAIL post_reset_search: got lk=%0b idx=%0d ok=%0b expected lk=0 idx=6 ok=1",
                     locked, idx, onehot_ok);
        end
        drive_sample(8'h20, 1'b0);
        checks++;
        if ({locked, idx, rev_cnt} !== {1'b1, 3'd5, 8'd0}) begin
            failures++;
            $display("[TB] FAIL post_reset_lock: got lk=%0b idx=%0d rc=%0d expected lk=1 idx=5 rc=0",
                     locked, idx, rev_cnt);
        end
    endtask

    // Scenario sequence. Each task starts from the state the previous one
    // left behind.
    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        ring_in  = '0;
        ring_vld = 1'b0;
        clr_err  = 1'b0;

        test_reset();
        test_lock_revolution();
        test_illegal_locked();
        test_clear_error();
        test_wrong_direction();
        test_gaps();
        test_error_count();
        test_async_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
